// File: rtl/uart_tx_serializer.sv
// UART transmitter: byte-wide valid/ready write port into a small circular FIFO,
// drained by an FSM that serializes 8N1 / 8E1 frames LSB first onto a registered tx_o.
module uart_tx_serializer #(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DIV_WIDTH-1:0]          cfg_div_i,
  input  logic                          cfg_parity_en_i,
  input  logic                          tx_valid_i,
  input  logic [7:0]                    tx_data_i,
  output logic                          tx_ready_o,
  output logic                          tx_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_L = FIFO_DEPTH[AW:0];

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  logic [7:0]           mem_q [FIFO_DEPTH];
  logic [AW:0]          wr_ptr_q, rd_ptr_q, level;
  logic                 full, empty, push, pop;
  logic [7:0]           head;

  state_e               state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d, div_q, div_d;
  logic [7:0]           shift_q, shift_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic                 par_en_q, par_en_d, par_q, par_d, tx_q, tx_d;

  // Pointers carry one extra bit so full and empty are distinguishable.
  assign level = wr_ptr_q - rd_ptr_q;
  assign full  = (level == DEPTH_L);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign push  = tx_valid_i && !full;
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= tx_data_i;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    par_en_d  = par_en_q;
    par_d     = par_q;
    tx_d      = tx_q;
    pop       = 1'b0;
    if (state_q == IDLE) begin
      pop = !empty;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - DIV_WIDTH'(1);
    end else begin
      cnt_d = div_q;
      unique case (state_q)
        START: begin
          state_d = DATA;
          tx_d    = shift_q[0];
        end
        DATA: begin
          if (bit_idx_q == 3'd7) begin
            state_d = par_en_q ? PARITY : STOP;
            tx_d    = par_en_q ? par_q : 1'b1;
          end else begin
            shift_d   = {1'b0, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shift_q[1];
          end
        end
        PARITY: begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
        default: begin
          // End of stop bit: chain straight into the next queued byte.
          state_d = IDLE;
          tx_d    = 1'b1;
          pop     = !empty;
        end
      endcase
    end
    if (pop) begin
      state_d   = START;
      tx_d      = 1'b0;
      shift_d   = head;
      par_d     = ^head;
      div_d     = cfg_div_i;
      cnt_d     = cfg_div_i;
      par_en_d  = cfg_parity_en_i;
      bit_idx_d = 3'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      par_en_q  <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      par_en_q  <= par_en_d;
      tx_q      <= tx_d;
    end
  end

  always_ff @(posedge clk) begin
    div_q   <= div_d;
    shift_q <= shift_d;
    par_q   <= par_d;
  end

  assign tx_ready_o   = !full;
  assign tx_o         = tx_q;
  assign busy_o       = (state_q != IDLE) || !empty;
  assign fifo_level_o = level;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer: stimulus queues expected frames,
// a line monitor decodes tx_o cycle by cycle and compares against them.
module tb_uart_tx_serializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cfg_div;
  logic        cfg_par;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready, tx_line, busy;
  logic [3:0]  level;

  uart_tx_serializer #(.FIFO_DEPTH(8), .DIV_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_div_i(cfg_div), .cfg_parity_en_i(cfg_par),
    .tx_valid_i(tx_valid), .tx_data_i(tx_data), .tx_ready_o(tx_ready),
    .tx_o(tx_line), .busy_o(busy), .fifo_level_o(level));

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         div;
    bit         pe;
    bit         pb;
    bit         b2b;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   abort = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic expect_frame(input logic [7:0] d, input int dv, input bit pe, input bit pb, input bit b2b);
    exp_t e;
    e.data = d; e.div = dv; e.pe = pe; e.pb = pb; e.b2b = b2b;
    exp_q.push_back(e);
  endtask

  // Line monitor: every low seen on an idle line must start an expected frame.
  initial begin : monitor
    int prev_end = -100;
    forever begin
      @(negedge clk);
      if (!abort && rst_n && tx_line === 1'b0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 32'd1, 32'd0);
        end else begin
          exp_t e;
          int len, per, pos, mism, start_cyc;
          logic [7:0] got;
          logic expbit;
          bit aborted;
          e = exp_q.pop_front();
          per = e.div + 1;
          len = per * (10 + int'(e.pe));
          mism = 0; got = 8'h00; aborted = 1'b0;
          start_cyc = cyc;
          if (e.b2b) check("b2b_gap", 32'(start_cyc - prev_end), 32'd1);
          for (int k = 0; k < len; k++) begin
            if (k > 0) @(negedge clk);
            if (abort) begin aborted = 1'b1; break; end
            pos = k / per;
            if (pos == 0)                expbit = 1'b0;
            else if (pos <= 8)           expbit = e.data[pos-1];
            else if (e.pe && pos == 9)   expbit = e.pb;
            else                         expbit = 1'b1;
            if (tx_line !== expbit) mism++;
            if (pos >= 1 && pos <= 8 && (k % per) == e.div / 2) got[pos-1] = tx_line;
          end
          if (!aborted) begin
            prev_end = cyc;
            check("frame_data", {24'd0, got}, {24'd0, e.data});
            check("frame_wave_mismatch_cycles", 32'(mism), 32'd0);
          end
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input int dv, input bit pe, input bit pb, input bit b2b);
    int t = 0;
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = d;
    while (!tx_ready && t < 1000) begin @(negedge clk); t++; end
    check("send_ready_timeout", 32'(t < 1000), 32'd1);
    expect_frame(d, dv, pe, pb, b2b);
    @(posedge clk);
    #1 tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((exp_q.size() != 0 || busy) && t < 5000) begin @(negedge clk); t++; end
    check("idle_timeout", 32'(t < 5000), 32'd1);
  endtask

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [7:0] b3 [12];
    logic [7:0] hello [6];
    int n, t, lows;
    bit saw_full, acc;
    b3    = '{8'h00, 8'hFF, 8'h01, 8'h80, 8'h3C, 8'hC3, 8'h5A, 8'hA5, 8'h0F, 8'hF0, 8'h11, 8'hEE};
    hello = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h0A};

    rst_n = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; cfg_div = 16'd3; cfg_par = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx_line), 32'd1);
    check("rst_ready", 32'(tx_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 0x55 at div=3: first-byte latency and end-of-frame busy timing.
    tx_valid = 1'b1; tx_data = 8'h55;
    expect_frame(8'h55, 3, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
    check("t1_level_after_push", 32'(level), 32'd1);
    check("t1_tx_still_idle", 32'(tx_line), 32'd1);
    @(negedge clk);
    check("t1_start_low", 32'(tx_line), 32'd0);
    check("t1_level_after_pop", 32'(level), 32'd0);
    repeat (39) @(negedge clk);
    check("t1_busy_in_stop", 32'(busy), 32'd1);
    check("t1_stop_high", 32'(tx_line), 32'd1);
    @(negedge clk);
    check("t1_busy_after_frame", 32'(busy), 32'd0);
    wait_idle();

    // Even parity: 0x07 -> 1, 0x03 -> 0.
    cfg_par = 1'b1;
    send(8'h07, 3, 1'b1, 1'b1, 1'b0);
    send(8'h03, 3, 1'b1, 1'b0, 1'b1);
    wait_idle();
    cfg_par = 1'b0;

    // Continuous valid for 12 bytes at div=1: FIFO fills, frames chain.
    cfg_div = 16'd1;
    n = 0; t = 0; saw_full = 1'b0;
    @(negedge clk);
    tx_valid = 1'b1; tx_data = b3[0];
    while (n < 12 && t < 2000) begin
      if (level == 4'd8 && !tx_ready) saw_full = 1'b1;
      acc = tx_ready;
      if (acc) expect_frame(b3[n], 1, 1'b0, 1'b0, n > 0);
      @(posedge clk);
      @(negedge clk);
      if (acc) n++;
      if (n < 12) tx_data = b3[n];
      t++;
    end
    tx_valid = 1'b0;
    check("t3_all_accepted", 32'(n), 32'd12);
    check("t3_ready_low_when_full", 32'(saw_full), 32'd1);
    wait_idle();

    // Divisor change mid-frame applies only to the next frame.
    cfg_div = 16'd3;
    send(8'hC9, 3, 1'b0, 1'b0, 1'b0);
    send(8'h36, 7, 1'b0, 1'b0, 1'b1);
    repeat (8) @(negedge clk);
    cfg_div = 16'd7;
    wait_idle();

    // "hello\n" at 1 cycle per bit.
    cfg_div = 16'd0;
    for (int i = 0; i < 6; i++) send(hello[i], 0, 1'b0, 1'b0, i > 0);
    wait_idle();

    // Reset during data bit 4 with three bytes queued.
    cfg_div = 16'd3;
    @(negedge clk);
    tx_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tx_data = 8'hA1 + 8'(i);
      expect_frame(tx_data, 3, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      @(negedge clk);
    end
    tx_valid = 1'b0;
    repeat (18) @(negedge clk);
    check("t5_level_before_reset", 32'(level), 32'd3);
    abort = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_tx_high", 32'(tx_line), 32'd1);
    check("t5_level_zero", 32'(level), 32'd0);
    check("t5_ready", 32'(tx_ready), 32'd1);
    check("t5_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    exp_q.delete();
    abort = 1'b0;
    lows = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx_line !== 1'b1) lows++;
    end
    check("t5_no_frames_after_reset", 32'(lows), 32'd0);
    check("t5_idle_after_reset", 32'(busy), 32'd0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
